// File: rtl/butcher_bill_tally.sv
// Streaming item pricer and per-customer bill accumulator.
// Two-stage pipeline: table lookup, then saturating accumulate; bill on checkout.
module butcher_bill_tally #(
    parameter int CODE_W  = 3,
    parameter int PRICE_W = 12,
    parameter int QTY_W   = 4,
    parameter int TOTAL_W = 20,
    parameter int CNT_W   = 8,
    parameter logic [PRICE_W*(2**CODE_W)-1:0] PRICE_TABLE = {
        12'd100, 12'd200, 12'd600, 12'd0,
        12'd0,   12'd0,   12'd0,   12'd1000
    },
    parameter logic [(2**CODE_W)-1:0] MATCH_MASK = 8'b1110_0001
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     item_valid,
    output logic                     item_ready,
    input  logic [CODE_W-1:0]        item_code,
    input  logic [QTY_W-1:0]         item_qty,
    input  logic                     checkout,
    output logic                     line_valid,
    output logic [PRICE_W+QTY_W-1:0] line_price,
    output logic                     line_miss,
    output logic                     bill_valid,
    input  logic                     bill_ready,
    output logic [TOTAL_W-1:0]       bill_total,
    output logic [CNT_W-1:0]         bill_items,
    output logic [CNT_W-1:0]         bill_misses,
    output logic                     bill_overflow
);

    localparam int LP_W = PRICE_W + QTY_W;
    localparam int TS_W = ((TOTAL_W > LP_W) ? TOTAL_W : LP_W) + 1;
    localparam int IS_W = ((CNT_W > QTY_W) ? CNT_W : QTY_W) + 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        REPORT
    } state_t;

    state_t state, state_n;
    logic   drain_cnt;

    logic               accept;
    logic [PRICE_W-1:0] price_lu;

    logic               s1_valid;
    logic               s1_match;
    logic [PRICE_W-1:0] s1_price;
    logic [QTY_W-1:0]   s1_qty;

    logic [TOTAL_W-1:0] total;
    logic [CNT_W-1:0]   items;
    logic [CNT_W-1:0]   misses;
    logic               overflow;

    logic [TS_W-1:0]    tot_sum;
    logic [IS_W-1:0]    itm_sum;
    logic [CNT_W:0]     mis_sum;
    logic               tot_sat;
    logic               itm_sat;
    logic               mis_sat;
    logic               take;

    assign item_ready = (state == IDLE) || (state == ACCUM);
    assign accept     = item_valid && item_ready;
    assign bill_valid = (state == REPORT);
    assign take       = bill_valid && bill_ready;

    always_comb begin
        price_lu = '0;
        for (int k = 0; k < 2**CODE_W; k++) begin
            if (item_code == CODE_W'(k)) begin
                price_lu = PRICE_TABLE[k*PRICE_W +: PRICE_W];
            end
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE, ACCUM: begin
                if (checkout) begin
                    state_n = DRAIN;
                end else if (accept) begin
                    state_n = ACCUM;
                end
            end
            DRAIN: begin
                if (drain_cnt) begin
                    state_n = REPORT;
                end
            end
            REPORT: begin
                if (bill_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            drain_cnt <= 1'b0;
        end else begin
            state     <= state_n;
            drain_cnt <= (state == DRAIN) && !drain_cnt;
        end
    end

    // Idle stage-1 slots hold zero so line_price reads 0 between lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_match <= 1'b0;
            s1_price <= '0;
            s1_qty   <= '0;
        end else begin
            s1_valid <= accept;
            s1_match <= accept && MATCH_MASK[item_code];
            s1_price <= accept ? price_lu : '0;
            s1_qty   <= accept ? item_qty : '0;
        end
    end

    assign line_valid = s1_valid;
    assign line_miss  = s1_valid && !s1_match;
    assign line_price = {{QTY_W{1'b0}}, s1_price} * {{PRICE_W{1'b0}}, s1_qty};

    always_comb begin
        tot_sum = TS_W'(total) + TS_W'(line_price);
        itm_sum = IS_W'(items) + IS_W'(s1_qty);
        mis_sum = {1'b0, misses} + (CNT_W+1)'(1);
        tot_sat = tot_sum > TS_W'({TOTAL_W{1'b1}});
        itm_sat = itm_sum > IS_W'({CNT_W{1'b1}});
        mis_sat = mis_sum[CNT_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total    <= '0;
            items    <= '0;
            misses   <= '0;
            overflow <= 1'b0;
        end else if (take) begin
            total    <= '0;
            items    <= '0;
            misses   <= '0;
            overflow <= 1'b0;
        end else if (s1_valid && s1_match) begin
            total    <= tot_sat ? {TOTAL_W{1'b1}} : tot_sum[TOTAL_W-1:0];
            items    <= itm_sat ? {CNT_W{1'b1}} : itm_sum[CNT_W-1:0];
            overflow <= overflow || tot_sat || itm_sat;
        end else if (s1_valid) begin
            misses   <= mis_sat ? {CNT_W{1'b1}} : mis_sum[CNT_W-1:0];
            overflow <= overflow || mis_sat;
        end
    end

    assign bill_total    = total;
    assign bill_items    = items;
    assign bill_misses   = misses;
    assign bill_overflow = overflow;

endmodule

// File: tb/tb_butcher_bill_tally.sv
// Directed bench for butcher_bill_tally: default build plus a 12-bit-total
// build used to exercise total saturation.
module tb_butcher_bill_tally;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        item_valid = 1'b0;
    logic        item_ready;
    logic [2:0]  item_code = '0;
    logic [3:0]  item_qty = '0;
    logic        checkout = 1'b0;
    logic        line_valid;
    logic [15:0] line_price;
    logic        line_miss;
    logic        bill_valid;
    logic        bill_ready = 1'b0;
    logic [19:0] bill_total;
    logic [7:0]  bill_items;
    logic [7:0]  bill_misses;
    logic        bill_overflow;

    logic        s_item_valid = 1'b0;
    logic        s_item_ready;
    logic [2:0]  s_item_code = '0;
    logic [3:0]  s_item_qty = '0;
    logic        s_checkout = 1'b0;
    logic        s_line_valid;
    logic [15:0] s_line_price;
    logic        s_line_miss;
    logic        s_bill_valid;
    logic        s_bill_ready = 1'b0;
    logic [11:0] s_bill_total;
    logic [7:0]  s_bill_items;
    logic [7:0]  s_bill_misses;
    logic        s_bill_overflow;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    butcher_bill_tally u_dut (
        .clk(clk), .rst(rst),
        .item_valid(item_valid), .item_ready(item_ready),
        .item_code(item_code), .item_qty(item_qty),
        .checkout(checkout),
        .line_valid(line_valid), .line_price(line_price),
        .line_miss(line_miss),
        .bill_valid(bill_valid), .bill_ready(bill_ready),
        .bill_total(bill_total), .bill_items(bill_items),
        .bill_misses(bill_misses), .bill_overflow(bill_overflow)
    );

    butcher_bill_tally #(.TOTAL_W(12)) u_sat (
        .clk(clk), .rst(rst),
        .item_valid(s_item_valid), .item_ready(s_item_ready),
        .item_code(s_item_code), .item_qty(s_item_qty),
        .checkout(s_checkout),
        .line_valid(s_line_valid), .line_price(s_line_price),
        .line_miss(s_line_miss),
        .bill_valid(s_bill_valid), .bill_ready(s_bill_ready),
        .bill_total(s_bill_total), .bill_items(s_bill_items),
        .bill_misses(s_bill_misses), .bill_overflow(s_bill_overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_item(input logic [2:0] c, input logic [3:0] q);
        item_valid = 1'b1;
        item_code  = c;
        item_qty   = q;
    endtask

    // Checkout from IDLE/ACCUM; returns in the first REPORT cycle (C+3).
    task automatic do_checkout();
        item_valid = 1'b0;
        checkout   = 1'b1;
        tick();
        checkout   = 1'b0;
        tick();
        tick();
    endtask

    task automatic take_bill();
        bill_ready = 1'b1;
        tick();
        bill_ready = 1'b0;
    endtask

    task automatic test_reset();
        tests++;
        if ({item_ready, line_valid, line_price, line_miss, bill_valid} !== {1'b1, 1'b0, 16'd0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_ctrl got rdy=%0b lv=%0b lp=%0d lm=%0b bv=%0b want 1 0 0 0 0",
                     item_ready, line_valid, line_price, line_miss, bill_valid);
        end
        tests++;
        if ({bill_total, bill_items, bill_misses, bill_overflow} !== 37'd0) begin
            fails++;
            $display("FAIL reset_bill got t=%0d i=%0d m=%0d o=%0b want 0 0 0 0",
                     bill_total, bill_items, bill_misses, bill_overflow);
        end
    endtask

    task automatic test_defaults();
        drive_item(3'd0, 4'd2);
        tick();
        tests++;
        if ({line_valid, line_price, line_miss} !== {1'b1, 16'd2000, 1'b0}) begin
            fails++;
            $display("FAIL def_line0 got lv=%0b lp=%0d lm=%0b want 1 2000 0", line_valid, line_price, line_miss);
        end
        drive_item(3'd5, 4'd1);
        tick();
        tests++;
        if ({line_valid, line_price, bill_total} !== {1'b1, 16'd600, 20'd2000}) begin
            fails++;
            $display("FAIL def_line1 got lv=%0b lp=%0d t=%0d want 1 600 2000", line_valid, line_price, bill_total);
        end
        item_valid = 1'b0;
        checkout   = 1'b1;
        tick();
        checkout   = 1'b0;
        tests++;
        if ({bill_valid, item_ready} !== 2'b00) begin
            fails++;
            $display("FAIL def_drain1 got bv=%0b rdy=%0b want 0 0", bill_valid, item_ready);
        end
        tick();
        tests++;
        if (bill_valid !== 1'b0) begin
            fails++;
            $display("FAIL def_drain2 got bv=%0b want 0", bill_valid);
        end
        tick();
        tests++;
        if ({bill_valid, bill_total, bill_items, bill_misses, bill_overflow} !== {1'b1, 20'd2600, 8'd3, 8'd0, 1'b0}) begin
            fails++;
            $display("FAIL def_bill got bv=%0b t=%0d i=%0d m=%0d o=%0b want 1 2600 3 0 0",
                     bill_valid, bill_total, bill_items, bill_misses, bill_overflow);
        end
        take_bill();
        tests++;
        if ({bill_valid, item_ready, bill_total, bill_items} !== {1'b0, 1'b1, 20'd0, 8'd0}) begin
            fails++;
            $display("FAIL def_taken got bv=%0b rdy=%0b t=%0d i=%0d want 0 1 0 0",
                     bill_valid, item_ready, bill_total, bill_items);
        end
    endtask

    task automatic test_miss();
        logic [2:0]  codes [3] = '{3'd1, 3'd7, 3'd3};
        logic [3:0]  qtys  [3] = '{4'd3, 4'd4, 4'd1};
        logic        exp_m [3] = '{1'b1, 1'b0, 1'b1};
        logic [15:0] exp_p [3] = '{16'd0, 16'd400, 16'd0};
        drive_item(codes[0], qtys[0]);
        for (int k = 0; k < 3; k++) begin
            tick();
            if (k < 2) drive_item(codes[k+1], qtys[k+1]);
            else item_valid = 1'b0;
            tests++;
            if ({line_valid, line_miss, line_price} !== {1'b1, exp_m[k], exp_p[k]}) begin
                fails++;
                $display("FAIL miss_line%0d got lv=%0b lm=%0b lp=%0d want 1 %0b %0d",
                         k, line_valid, line_miss, line_price, exp_m[k], exp_p[k]);
            end
        end
        do_checkout();
        tests++;
        if ({bill_valid, bill_total, bill_items, bill_misses, bill_overflow} !== {1'b1, 20'd400, 8'd4, 8'd2, 1'b0}) begin
            fails++;
            $display("FAIL miss_bill got bv=%0b t=%0d i=%0d m=%0d o=%0b want 1 400 4 2 0",
                     bill_valid, bill_total, bill_items, bill_misses, bill_overflow);
        end
        take_bill();
    endtask

    task automatic test_same_cycle();
        drive_item(3'd6, 4'd1);
        checkout = 1'b1;
        tick();
        item_valid = 1'b0;
        checkout   = 1'b0;
        tests++;
        if ({line_valid, line_price, item_ready} !== {1'b1, 16'd200, 1'b0}) begin
            fails++;
            $display("FAIL same_line got lv=%0b lp=%0d rdy=%0b want 1 200 0", line_valid, line_price, item_ready);
        end
        checkout = 1'b1;
        tick();
        tests++;
        if ({item_ready, bill_valid} !== 2'b00) begin
            fails++;
            $display("FAIL same_drain2 got rdy=%0b bv=%0b want 0 0", item_ready, bill_valid);
        end
        tick();
        checkout = 1'b0;
        drive_item(3'd0, 4'd1);
        for (int k = 0; k < 5; k++) begin
            tests++;
            if ({bill_valid, item_ready, line_valid, bill_total, bill_items, bill_misses}
                !== {1'b1, 1'b0, 1'b0, 20'd200, 8'd1, 8'd0}) begin
                fails++;
                $display("FAIL same_hold%0d got bv=%0b rdy=%0b lv=%0b t=%0d i=%0d m=%0d want 1 0 0 200 1 0",
                         k, bill_valid, item_ready, line_valid, bill_total, bill_items, bill_misses);
            end
            tick();
        end
        item_valid = 1'b0;
        take_bill();
        tests++;
        if ({bill_valid, item_ready, line_valid, bill_total} !== {1'b0, 1'b1, 1'b0, 20'd0}) begin
            fails++;
            $display("FAIL same_taken got bv=%0b rdy=%0b lv=%0b t=%0d want 0 1 0 0",
                     bill_valid, item_ready, line_valid, bill_total);
        end
    endtask

    task automatic test_total_saturation();
        s_item_valid = 1'b1;
        s_item_code  = 3'd0;
        s_item_qty   = 4'd5;
        tick();
        s_item_qty   = 4'd1;
        tests++;
        if (s_line_price !== 16'd5000) begin
            fails++;
            $display("FAIL sat_line got lp=%0d want 5000", s_line_price);
        end
        tick();
        s_item_valid = 1'b0;
        s_checkout   = 1'b1;
        tick();
        s_checkout   = 1'b0;
        tick();
        tick();
        tests++;
        if ({s_bill_valid, s_bill_total, s_bill_items, s_bill_overflow} !== {1'b1, 12'd4095, 8'd6, 1'b1}) begin
            fails++;
            $display("FAIL sat_bill got bv=%0b t=%0d i=%0d o=%0b want 1 4095 6 1",
                     s_bill_valid, s_bill_total, s_bill_items, s_bill_overflow);
        end
        s_bill_ready = 1'b1;
        tick();
        s_bill_ready = 1'b0;
        s_checkout   = 1'b1;
        tick();
        s_checkout   = 1'b0;
        tick();
        tick();
        tests++;
        if ({s_bill_valid, s_bill_total, s_bill_overflow} !== {1'b1, 12'd0, 1'b0}) begin
            fails++;
            $display("FAIL sat_next got bv=%0b t=%0d o=%0b want 1 0 0", s_bill_valid, s_bill_total, s_bill_overflow);
        end
        s_bill_ready = 1'b1;
        tick();
        s_bill_ready = 1'b0;
    endtask

    task automatic test_items_saturation();
        drive_item(3'd0, 4'd15);
        repeat (18) tick();
        do_checkout();
        tests++;
        if ({bill_total, bill_items, bill_misses, bill_overflow} !== {20'd270000, 8'd255, 8'd0, 1'b1}) begin
            fails++;
            $display("FAIL isat_bill got t=%0d i=%0d m=%0d o=%0b want 270000 255 0 1",
                     bill_total, bill_items, bill_misses, bill_overflow);
        end
        take_bill();
    endtask

    task automatic test_empty_and_qty0();
        do_checkout();
        tests++;
        if ({bill_valid, bill_total, bill_items, bill_misses, bill_overflow} !== {1'b1, 37'd0}) begin
            fails++;
            $display("FAIL empty_bill got bv=%0b t=%0d i=%0d m=%0d o=%0b want 1 0 0 0 0",
                     bill_valid, bill_total, bill_items, bill_misses, bill_overflow);
        end
        take_bill();
        drive_item(3'd0, 4'd0);
        tick();
        item_valid = 1'b0;
        tests++;
        if ({line_valid, line_price, line_miss} !== {1'b1, 16'd0, 1'b0}) begin
            fails++;
            $display("FAIL qty0_line got lv=%0b lp=%0d lm=%0b want 1 0 0", line_valid, line_price, line_miss);
        end
        do_checkout();
        tests++;
        if ({bill_valid, bill_total, bill_items, bill_misses, bill_overflow} !== {1'b1, 37'd0}) begin
            fails++;
            $display("FAIL qty0_bill got bv=%0b t=%0d i=%0d m=%0d o=%0b want 1 0 0 0 0",
                     bill_valid, bill_total, bill_items, bill_misses, bill_overflow);
        end
        take_bill();
    endtask

    task automatic test_async_reset();
        drive_item(3'd0, 4'd1);
        tick();
        item_valid = 1'b0;
        checkout   = 1'b1;
        tick();
        checkout   = 1'b0;
        tests++;
        if ({item_ready, bill_total} !== {1'b0, 20'd1000}) begin
            fails++;
            $display("FAIL rst_pre got rdy=%0b t=%0d want 0 1000", item_ready, bill_total);
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if ({item_ready, line_valid, line_price, line_miss, bill_valid,
             bill_total, bill_items, bill_misses, bill_overflow}
            !== {1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 37'd0}) begin
            fails++;
            $display("FAIL rst_async got rdy=%0b lv=%0b lp=%0d bv=%0b t=%0d i=%0d want 1 0 0 0 0 0",
                     item_ready, line_valid, line_price, bill_valid, bill_total, bill_items);
        end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            tests++;
            if ({bill_valid, item_ready} !== 2'b01) begin
                fails++;
                $display("FAIL rst_nobill%0d got bv=%0b rdy=%0b want 0 1", k, bill_valid, item_ready);
            end
        end
        drive_item(3'd7, 4'd2);
        tick();
        item_valid = 1'b0;
        tests++;
        if ({line_valid, line_price} !== {1'b1, 16'd200}) begin
            fails++;
            $display("FAIL rst_newline got lv=%0b lp=%0d want 1 200", line_valid, line_price);
        end
        do_checkout();
        tests++;
        if ({bill_valid, bill_total, bill_items} !== {1'b1, 20'd200, 8'd2}) begin
            fails++;
            $display("FAIL rst_newbill got bv=%0b t=%0d i=%0d want 1 200 2", bill_valid, bill_total, bill_items);
        end
        take_bill();
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        tick();
        test_reset();
        test_defaults();
        test_miss();
        test_same_cycle();
        test_total_saturation();
        test_items_saturation();
        test_empty_and_qty0();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
